sprite_commit_sched: RTL and testbench

- Buffers sprite position updates from the game/CPU side.
- Commits each update to the sprite position register file over its sprite_id / sprite_x / sprite_y / wrn write port, and only during vertical blanking, so plates and ball never tear mid-frame.
- Sits between the game-logic bus and the sprite renderer.
- Owns the wrn strobe timing: the sprite register file latches on the rising edge of wrn.

---
 rtl/sprite_commit_sched.sv | 126 ++++++++++++
 tb/tb_sprite_commit_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_commit_sched.sv
`default_nettype none
// ============================================================================
// sprite_commit_sched: queues sprite position updates and commits each one to
// the sprite register file with a registered wrn strobe during vblank only.
// Revision: 1.0
// ============================================================================
module sprite_commit_sched #(
  parameter int DEPTH       = 4,
  parameter int NUM_SPRITES = 3,
  parameter int SETUP_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_id,
  input  logic [9:0] req_x,
  input  logic [8:0] req_y,
  input  logic       vblank,
  output logic [7:0] sprite_id,
  output logic [9:0] sprite_x,
  output logic [8:0] sprite_y,
  output logic       wrn,
  output logic       busy,
  output logic       bad_id
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH + 1);
  localparam int c_sw = $clog2(SETUP_CYC + 1);
  localparam logic [c_cw-1:0] c_full       = c_cw'(DEPTH);
  localparam logic [c_sw-1:0] c_setup_init = c_sw'(SETUP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            r_state, w_next_state;
  logic [c_sw-1:0]   r_cnt, w_next_cnt;
  logic [c_aw-1:0]   r_rd_ptr, r_wr_ptr;
  logic [c_cw-1:0]   r_count;
  logic [26:0]       r_mem [DEPTH];
  logic [7:0]        r_id;
  logic [9:0]        r_x;
  logic [8:0]        r_y;
  logic              r_wrn, r_bad_id;
  logic              w_accept, w_id_ok, w_push, w_pop;

  assign req_ready = (r_count != c_full);
  assign w_accept  = req_valid && req_ready;
  assign w_id_ok   = ({24'd0, req_id} < 32'(NUM_SPRITES));
  assign w_push    = w_accept && w_id_ok;

  // Storage needs no reset: entries are only read when count says they exist.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {req_id, req_x, req_y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_bad_id <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept && !w_id_ok) r_bad_id <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_count != '0) && vblank) begin
          w_pop        = 1'b1;
          w_next_state = SETUP;
          w_next_cnt   = c_setup_init;
        end
      end
      SETUP: begin
        if (r_cnt == '0) w_next_state = STROBE;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      STROBE:  w_next_state = HOLD;
      HOLD:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // wrn is decoded from the next state so it comes straight off a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wrn   <= 1'b0;
      r_id    <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_wrn   <= (w_next_state == STROBE);
      if (w_pop) {r_id, r_x, r_y} <= r_mem[r_rd_ptr];
    end
  end

  assign sprite_id = r_id;
  assign sprite_x  = r_x;
  assign sprite_y  = r_y;
  assign wrn       = r_wrn;
  assign bad_id    = r_bad_id;
  assign busy      = (r_state != IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_sprite_commit_sched.sv
`default_nettype none
// ============================================================================
// tb_sprite_commit_sched: directed self-checking bench for sprite_commit_sched.
// Revision: 1.0
// ============================================================================
module tb_sprite_commit_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_id = '0;
  logic [9:0] req_x = '0;
  logic [8:0] req_y = '0;
  logic       vblank = 1'b1;
  logic [7:0] sprite_id;
  logic [9:0] sprite_x;
  logic [8:0] sprite_y;
  logic       wrn, busy, bad_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         s_cnt = 0;
  logic [7:0] s_id  [64];
  logic [9:0] s_x   [64];
  logic [8:0] s_y   [64];
  int         s_cyc [64];

  sprite_commit_sched #(.DEPTH(4), .NUM_SPRITES(3), .SETUP_CYC(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_x(req_x), .req_y(req_y), .vblank(vblank),
    .sprite_id(sprite_id), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .wrn(wrn), .busy(busy), .bad_id(bad_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Each negedge with wrn high is one strobe cycle; a two-cycle strobe logs twice.
  always @(negedge clk) begin
    if (wrn && s_cnt < 64) begin
      s_id[s_cnt]  = sprite_id;
      s_x[s_cnt]   = sprite_x;
      s_y[s_cnt]   = sprite_y;
      s_cyc[s_cnt] = cyc;
      s_cnt        = s_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] id, input logic [9:0] x, input logic [8:0] y,
                      output int acc);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_id = id; req_x = x; req_y = y;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_timeout", 32'(req_ready), 32'd1);
    acc = cyc + 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int acc, acc5, b, vb_edge, n;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_wrn",   32'(wrn), 32'd0);
    check("rst_x",     32'(sprite_x), 32'd0);
    check("rst_id",    32'(sprite_id), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_bad",   32'(bad_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: single commit latency
    b = s_cnt;
    push(8'd0, 10'd320, 9'd460, acc);
    check("t1_busy_q", 32'(busy), 32'd1);
    wait_cyc(1);
    check("t1_x_load", 32'(sprite_x), 32'd320);
    check("t1_y_load", 32'(sprite_y), 32'd460);
    check("t1_wrn_lo", 32'(wrn), 32'd0);
    wait_cyc(2);
    check("t1_wrn_hi", 32'(wrn), 32'd1);
    wait_cyc(1);
    check("t1_wrn_hold", 32'(wrn), 32'd0);
    check("t1_busy_hold", 32'(busy), 32'd1);
    wait_cyc(1);
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_strobes", 32'(s_cnt - b), 32'd1);
    check("t1_lat", 32'(s_cyc[b] - acc), 32'd3);

    // Test 2: hold off outside vblank, then three in-order commits
    vblank = 1'b0;
    b = s_cnt;
    push(8'd0, 10'd100, 9'd10, acc);
    push(8'd1, 10'd200, 9'd20, acc);
    push(8'd2, 10'd300, 9'd30, acc);
    wait_cyc(10);
    check("t2_no_wrn", 32'(s_cnt - b), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    vblank = 1'b1;
    wait_cyc(25);
    check("t2_strobes", 32'(s_cnt - b), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("t2_id", 32'(s_id[b+i]), 32'(i));
      check("t2_x",  32'(s_x[b+i]),  32'(100 * (i + 1)));
    end
    check("t2_space01", 32'(s_cyc[b+1] - s_cyc[b]), 32'd5);
    check("t2_space12", 32'(s_cyc[b+2] - s_cyc[b+1]), 32'd5);

    // Test 3: full FIFO back-pressure
    vblank = 1'b0;
    b = s_cnt;
    push(8'd0, 10'd11, 9'd1, acc);
    push(8'd1, 10'd12, 9'd2, acc);
    push(8'd2, 10'd13, 9'd3, acc);
    push(8'd0, 10'd14, 9'd4, acc);
    check("t3_full_ready", 32'(req_ready), 32'd0);
    vb_edge = 0;
    fork
      push(8'd1, 10'd15, 9'd5, acc5);
      begin
        @(negedge clk);
        @(negedge clk);
        vb_edge = cyc + 1;
        vblank = 1'b1;
      end
    join
    check("t3_acc5", 32'(acc5), 32'(vb_edge + 1));
    wait_cyc(40);
    check("t3_strobes", 32'(s_cnt - b), 32'd5);
    for (int i = 0; i < 5; i++) check("t3_x", 32'(s_x[b+i]), 32'(11 + i));
    check("t3_busy", 32'(busy), 32'd0);

    // Test 4: out-of-range id
    check("t4_bad_pre", 32'(bad_id), 32'd0);
    b = s_cnt;
    push(8'd7, 10'd99, 9'd99, acc);
    check("t4_bad_set", 32'(bad_id), 32'd1);
    wait_cyc(10);
    check("t4_no_wrn", 32'(s_cnt - b), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    push(8'd2, 10'd77, 9'd88, acc);
    wait_cyc(10);
    check("t4_strobes", 32'(s_cnt - b), 32'd1);
    check("t4_id", 32'(s_id[b]), 32'd2);
    check("t4_y", 32'(s_y[b]), 32'd88);
    check("t4_bad_sticky", 32'(bad_id), 32'd1);

    // Test 5: vblank drops during first SETUP
    vblank = 1'b0;
    b = s_cnt;
    push(8'd0, 10'd31, 9'd1, acc);
    push(8'd1, 10'd32, 9'd2, acc);
    push(8'd2, 10'd33, 9'd3, acc);
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    wait_cyc(20);
    check("t5_one", 32'(s_cnt - b), 32'd1);
    check("t5_x0", 32'(s_x[b]), 32'd31);
    check("t5_busy", 32'(busy), 32'd1);
    @(negedge clk);
    vblank = 1'b1;
    wait_cyc(20);
    check("t5_three", 32'(s_cnt - b), 32'd3);
    check("t5_x1", 32'(s_x[b+1]), 32'd32);
    check("t5_x2", 32'(s_x[b+2]), 32'd33);

    // Test 6: reset mid-strobe
    vblank = 1'b0;
    push(8'd1, 10'd41, 9'd1, acc);
    push(8'd2, 10'd42, 9'd2, acc);
    vblank = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wrn && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t6_wrn_seen", 32'(wrn), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_wrn", 32'(wrn), 32'd0);
    check("t6_x", 32'(sprite_x), 32'd0);
    check("t6_y", 32'(sprite_y), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_bad", 32'(bad_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    b = s_cnt;
    wait_cyc(20);
    check("t6_no_wrn", 32'(s_cnt - b), 32'd0);
    check("t6_busy_idle", 32'(busy), 32'd0);
    push(8'd0, 10'd55, 9'd66, acc);
    wait_cyc(10);
    check("t6_new", 32'(s_cnt - b), 32'd1);
    check("t6_new_x", 32'(s_x[b]), 32'd55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
